fetch_align_buffer: RTL and testbench
=====================================

Name: fetch_align_buffer

Overview:
- Instruction fetch/align stage sitting directly upstream of the decode stage.
- Accepts aligned 16-byte lines from the I-cache into a 2-line (32-byte) ring buffer.
- Presents to decode a 128-bit window of bytes starting at the current EIP.
- Advances the window by the variable instruction length decode reports, and restarts cleanly on a branch redirect.

Parameters:
- RESET_EIP, 32'h00000000, EIP fetched and presented after reset.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- ic_line  input  128  I-cache line data; byte k of the line is on ic_line[8k+7:8k].
- ic_v  input  1  ic_line is valid and corresponds to fetch_addr.
- ic_rdy  output  1  buffer accepts a line this cycle.
- fetch_addr  output  32  line address being requested; low 4 bits always 0.
- fe_instr  output  128  16 bytes from the head; head byte is on fe_instr[7:0].
- fe_v  output  1  fe_instr holds 16 valid bytes.
- fe_eip  output  32  EIP of the head byte.
- de_take  input  1  decode consumes an instruction this cycle.
- de_len  input  4  byte length of the consumed instruction, 1..15.
- br_v  input  1  redirect request.
- br_eip  input  32  redirect target EIP.

Behaviour:
- State
  - buf: 32 bytes, as 2 line slots.
  - wslot: 1 bit, next slot to write.
  - rd_ptr: 5 bits, byte index mod 32.
  - count: 0..32, valid bytes from rd_ptr up to end of last written slot.
  - skip: 4 bits.
  - FSM states FIRST and STREAM.
- Reset (rst_n=0 at posedge)
  - count=0, rd_ptr=0, wslot=0, state=FIRST.
  - fetch_addr={RESET_EIP[31:4],4'h0}, skip=RESET_EIP[3:0], fe_eip=RESET_EIP.
  - fe_v=0; buffer contents are don't-care.
  - Reset mid-stream discards everything.
- Combinational outputs
  - ic_rdy = (count <= 16) & !br_v.
  - fe_v = (count >= 16).
  - fe_instr byte i = buf[(rd_ptr+i) mod 32], for i = 0..15.
  - fe_instr is don't-care when fe_v=0.
- Line accept (ic_v & ic_rdy)
  - Write ic_line to slot wslot; wslot toggles; fetch_addr += 16 (32-bit wrap).
  - In FIRST: rd_ptr = {wslot,skip}, count = 16 - skip; state becomes STREAM.
  - In STREAM: count += 16.
- Consume (de_take & fe_v)
  - rd_ptr += de_len (mod 32), count -= de_len, fe_eip += de_len.
  - de_len=0 is a no-op.
  - de_take with fe_v=0 is ignored.
- Simultaneous accept and consume in STREAM: count = count + 16 - de_len. Both updates apply in the same cycle.
- Redirect (br_v=1) has highest priority; a line and a consume in the same cycle are dropped. Next cycle:
  - count=0, state=FIRST.
  - fetch_addr={br_eip[31:4],4'h0}, skip=br_eip[3:0], fe_eip=br_eip.
  - fe_v=0 on the cycle after br_v.
- Latency
  - First line accepted at cycle t → fe_v=1 at t+1 only if skip=0.
  - Otherwise fe_v waits for a second line (count must reach ≥16).
- Invariant: count never exceeds 32 and never underflows. ic_rdy guarantees the written slot holds no valid bytes.

Test Plan:
1. Reset, RESET_EIP=0x1000; supply lines 0x00..0x0F at 0x1000 and 0x10..0x1F at 0x1010 → fe_v=1 after first line, fe_instr[7:0]=0x00, fe_eip=0x1000; second line accepted; ic_rdy=0 when count=32.
2. Consume de_len=3, then 15, then 5 → fe_eip 0x1003, 0x1012, 0x1017; head bytes 0x03, 0x12, 0x17; wrap of rd_ptr past 31 shows correct byte order.
3. br_v with br_eip=0x2007 while count=24 and ic_v=1 → line dropped, fe_v=0 next cycle, fetch_addr=0x2000; after 2 lines, fe_instr[7:0]=byte 7 of line 0x2000, fe_eip=0x2007.
4. Simultaneous ic_v accept and de_take de_len=4 at count=16 → count=28, fetch_addr advances by 16, fe_eip +4.
5. de_take asserted with fe_v=0, and de_len=0 with fe_v=1 → no state change.
6. rst_n low mid-stream with count=20 → next cycle fe_v=0, fetch_addr={RESET_EIP[31:4],0}, fe_eip=RESET_EIP.

Source files
------------

// File: rtl/fetch_align_buffer.sv
// Fetch/align stage: buffers two 16-byte I-cache lines in a ring and presents a
// 16-byte window at the current EIP to decode, advancing by each instruction length.
module fetch_align_buffer #(
    parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] ic_line,
    input  logic         ic_v,
    output logic         ic_rdy,
    output logic [31:0]  fetch_addr,
    output logic [127:0] fe_instr,
    output logic         fe_v,
    output logic [31:0]  fe_eip,
    input  logic         de_take,
    input  logic [3:0]   de_len,
    input  logic         br_v,
    input  logic [31:0]  br_eip
);

    typedef enum logic {FIRST, STREAM} state_t;

    logic [127:0] line_buf_reg [2];
    logic [255:0] line_flat;

    state_t       state_reg, state_next;
    logic         wslot_reg, wslot_next;
    logic [4:0]   rd_ptr_reg, rd_ptr_next;
    logic [5:0]   count_reg, count_next;
    logic [3:0]   skip_reg, skip_next;
    logic [31:0]  fetch_addr_reg, fetch_addr_next;
    logic [31:0]  fe_eip_reg, fe_eip_next;

    logic         accept;
    logic         consume;

    assign ic_rdy     = (count_reg <= 6'd16) && !br_v;
    assign fe_v       = (count_reg >= 6'd16);
    assign fetch_addr = fetch_addr_reg;
    assign fe_eip     = fe_eip_reg;

    // ic_rdy already excludes redirect cycles; consume must too.
    assign accept  = ic_v && ic_rdy;
    assign consume = de_take && fe_v && !br_v;

    assign line_flat = {line_buf_reg[1], line_buf_reg[0]};

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_window
            logic [4:0] byte_idx;
            assign byte_idx = rd_ptr_reg + 5'(gi);
            assign fe_instr[8*gi +: 8] = line_flat[{byte_idx, 3'b000} +: 8];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        wslot_next      = wslot_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        skip_next       = skip_reg;
        fetch_addr_next = fetch_addr_reg;
        fe_eip_next     = fe_eip_reg;

        if (br_v) begin
            count_next      = 6'd0;
            state_next      = FIRST;
            fetch_addr_next = {br_eip[31:4], 4'h0};
            skip_next       = br_eip[3:0];
            fe_eip_next     = br_eip;
        end else begin
            if (accept) begin
                wslot_next      = ~wslot_reg;
                fetch_addr_next = fetch_addr_reg + 32'd16;
                if (state_reg == FIRST) begin
                    // The head starts mid-line when the target EIP is unaligned.
                    rd_ptr_next = {wslot_reg, skip_reg};
                    count_next  = 6'd16 - 6'(skip_reg);
                    state_next  = STREAM;
                end else begin
                    count_next  = count_reg + 6'd16;
                end
            end
            if (consume) begin
                rd_ptr_next = rd_ptr_reg + 5'(de_len);
                count_next  = count_next - 6'(de_len);
                fe_eip_next = fe_eip_reg + 32'(de_len);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= FIRST;
            wslot_reg      <= 1'b0;
            rd_ptr_reg     <= 5'd0;
            count_reg      <= 6'd0;
            skip_reg       <= RESET_EIP[3:0];
            fetch_addr_reg <= {RESET_EIP[31:4], 4'h0};
            fe_eip_reg     <= RESET_EIP;
        end else begin
            state_reg      <= state_next;
            wslot_reg      <= wslot_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            skip_reg       <= skip_next;
            fetch_addr_reg <= fetch_addr_next;
            fe_eip_reg     <= fe_eip_next;
        end
    end

    // Line data needs no reset: count gates its visibility.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            line_buf_reg[wslot_reg] <= ic_line;
        end
    end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer: fill, consume with wrap, redirect,
// simultaneous accept/consume, ignored consumes and mid-stream reset.
module tb_fetch_align_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] ic_line;
    logic         ic_v;
    logic         ic_rdy;
    logic [31:0]  fetch_addr;
    logic [127:0] fe_instr;
    logic         fe_v;
    logic [31:0]  fe_eip;
    logic         de_take;
    logic [3:0]   de_len;
    logic         br_v;
    logic [31:0]  br_eip;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_align_buffer #(.RESET_EIP(32'h0000_1000)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_line(ic_line), .ic_v(ic_v), .ic_rdy(ic_rdy), .fetch_addr(fetch_addr),
        .fe_instr(fe_instr), .fe_v(fe_v), .fe_eip(fe_eip),
        .de_take(de_take), .de_len(de_len),
        .br_v(br_v), .br_eip(br_eip)
    );

    // 16 consecutive byte values starting at b0 (byte 0 in bits [7:0]).
    function automatic logic [127:0] seq16(input logic [7:0] b0);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = b0 + 8'(k);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] b0, input logic t, input logic [3:0] l);
        ic_v    = v;
        ic_line = seq16(b0);
        de_take = t;
        de_len  = l;
    endtask

    initial begin
        rst_n = 1'b0; br_v = 1'b0; br_eip = '0;
        drive(1'b0, 8'h00, 1'b0, 4'd0);
        step(); step();
        chk("rst_fe_v",    128'(fe_v),       128'(1'b0));
        chk("rst_faddr",   128'(fetch_addr), 128'(32'h1000));
        chk("rst_eip",     128'(fe_eip),     128'(32'h1000));
        chk("rst_ic_rdy",  128'(ic_rdy),     128'(1'b1));

        // Test 1: two lines at 0x1000 / 0x1010
        rst_n = 1'b1;
        drive(1'b1, 8'h00, 1'b0, 4'd0); step();
        chk("l1_fe_v",     128'(fe_v),       128'(1'b1));
        chk("l1_instr",    fe_instr,         seq16(8'h00));
        chk("l1_eip",      128'(fe_eip),     128'(32'h1000));
        chk("l1_faddr",    128'(fetch_addr), 128'(32'h1010));
        drive(1'b1, 8'h10, 1'b0, 4'd0); step();
        chk("l2_ic_rdy",   128'(ic_rdy),     128'(1'b0));
        chk("l2_faddr",    128'(fetch_addr), 128'(32'h1020));

        // Test 2: consumes with rd_ptr wrap; a line offered while full is ignored
        drive(1'b1, 8'h20, 1'b1, 4'd3); step();
        chk("c3_eip",      128'(fe_eip),     128'(32'h1003));
        chk("c3_instr",    fe_instr,         seq16(8'h03));
        chk("c3_faddr",    128'(fetch_addr), 128'(32'h1020));
        drive(1'b0, 8'h20, 1'b1, 4'd15); step();
        chk("c15_eip",     128'(fe_eip),     128'(32'h1012));
        chk("c15_fe_v",    128'(fe_v),       128'(1'b0));
        chk("c15_head",    128'(fe_instr[7:0]), 128'(8'h12));
        drive(1'b1, 8'h20, 1'b0, 4'd0); step();
        chk("l3_fe_v",     128'(fe_v),       128'(1'b1));
        chk("l3_wrap",     fe_instr,         seq16(8'h12));
        drive(1'b0, 8'h00, 1'b1, 4'd5); step();
        chk("c5_eip",      128'(fe_eip),     128'(32'h1017));
        chk("c5_instr",    fe_instr,         seq16(8'h17));
        drive(1'b0, 8'h00, 1'b1, 4'd1); step();   // count 24

        // Test 3: redirect with line and consume in the same cycle
        br_v = 1'b1; br_eip = 32'h2007;
        drive(1'b1, 8'h30, 1'b1, 4'd2); #1;
        chk("br_ic_rdy",   128'(ic_rdy),     128'(1'b0));
        step();
        br_v = 1'b0;
        chk("br_fe_v",     128'(fe_v),       128'(1'b0));
        chk("br_faddr",    128'(fetch_addr), 128'(32'h2000));
        chk("br_eip",      128'(fe_eip),     128'(32'h2007));
        drive(1'b1, 8'h80, 1'b0, 4'd0); step();
        chk("bl1_fe_v",    128'(fe_v),       128'(1'b0));
        chk("bl1_faddr",   128'(fetch_addr), 128'(32'h2010));
        drive(1'b1, 8'h90, 1'b0, 4'd0); step();
        chk("bl2_fe_v",    128'(fe_v),       128'(1'b1));
        chk("bl2_instr",   fe_instr,         seq16(8'h87));
        chk("bl2_eip",     128'(fe_eip),     128'(32'h2007));

        // Test 4: simultaneous accept and consume at count 16
        drive(1'b0, 8'h00, 1'b1, 4'd9); step();
        chk("c9_eip",      128'(fe_eip),     128'(32'h2010));
        chk("c16_ic_rdy",  128'(ic_rdy),     128'(1'b1));
        drive(1'b1, 8'hA0, 1'b1, 4'd4); step();
        chk("sim_eip",     128'(fe_eip),     128'(32'h2014));
        chk("sim_faddr",   128'(fetch_addr), 128'(32'h2030));
        chk("sim_ic_rdy",  128'(ic_rdy),     128'(1'b0));
        chk("sim_instr",   fe_instr,         seq16(8'h94));
        drive(1'b0, 8'h00, 1'b1, 4'd12); step();  // 28-12 = 16 exactly
        chk("c12_fe_v",    128'(fe_v),       128'(1'b1));
        chk("c12_ic_rdy",  128'(ic_rdy),     128'(1'b1));
        chk("c12_eip",     128'(fe_eip),     128'(32'h2020));

        // Test 5: de_len=0 and de_take without fe_v are no-ops
        drive(1'b0, 8'h00, 1'b1, 4'd0); step();
        chk("l0_eip",      128'(fe_eip),     128'(32'h2020));
        chk("l0_fe_v",     128'(fe_v),       128'(1'b1));
        drive(1'b0, 8'h00, 1'b1, 4'd1); step();
        chk("c1_fe_v",     128'(fe_v),       128'(1'b0));
        drive(1'b0, 8'h00, 1'b1, 4'd4); step();
        chk("nov_eip",     128'(fe_eip),     128'(32'h2021));
        chk("nov_fe_v",    128'(fe_v),       128'(1'b0));

        // Test 6: reset mid-stream at count 20
        drive(1'b1, 8'hB0, 1'b0, 4'd0); step();
        chk("l4_instr",    fe_instr,         seq16(8'hA1));
        drive(1'b0, 8'h00, 1'b1, 4'd11); step();
        chk("c11_eip",     128'(fe_eip),     128'(32'h202C));
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 4'd0); step();
        chk("mrst_fe_v",   128'(fe_v),       128'(1'b0));
        chk("mrst_faddr",  128'(fetch_addr), 128'(32'h1000));
        chk("mrst_eip",    128'(fe_eip),     128'(32'h1000));
        rst_n = 1'b1;
        drive(1'b1, 8'h40, 1'b0, 4'd0); step();
        chk("mrst_instr",  fe_instr,         seq16(8'h40));
        chk("mrst_l_v",    128'(fe_v),       128'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
